// File: rtl/fetch_pkg.sv
// Shared types for the line-buffered instruction fetch block.
package fetch_pkg;

  // Storage widths of a line-buffer entry; instance widths must not exceed these.
  localparam int unsigned FETCH_TAG_MAX_W  = 64;
  localparam int unsigned FETCH_DATA_MAX_W = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                        valid;
    logic [FETCH_TAG_MAX_W-1:0]  tag;
    logic [FETCH_DATA_MAX_W-1:0] data;
  } line_entry_t;

endpackage

// File: rtl/fetch_line_lookup.sv
// Line-buffer tag compare and instruction select (purely combinational).
// With FETCH_PREFETCH_EN defined it also reports whether the next sequential line is present.
module fetch_line_lookup
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned LINE_BITS   = 512,
  parameter int unsigned NUM_LINES   = 2,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  line_entry_t             entries [NUM_LINES],
  input  logic [ADDR_WIDTH-1:0]   pc,
`ifdef FETCH_PREFETCH_EN
  output logic                    next_hit_c,
`endif
  output logic                    hit_c,
  output logic [INSTR_WIDTH-1:0]  instr_c
);

  localparam int unsigned LINE_BYTES = LINE_BITS / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  logic [ADDR_WIDTH-1:0] line_addr;
  logic [OFF_W-1:0]      offset;
  logic [LINE_BITS-1:0]  sel_data;

  assign line_addr = pc & ~OFF_MASK;
  assign offset    = pc[OFF_W-1:0];

  // Match the PC's line against every valid entry; the lowest index wins.
  always_comb begin
    hit_c    = 1'b0;
    sel_data = '0;
    for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].tag[ADDR_WIDTH-1:0] == line_addr)) begin
        hit_c    = 1'b1;
        sel_data = entries[i].data[LINE_BITS-1:0];
      end
    end
  end

  // Byte offset within the line selects the instruction.
  assign instr_c = INSTR_WIDTH'(sel_data >> {offset, 3'b000});

`ifdef FETCH_PREFETCH_EN
  logic [ADDR_WIDTH-1:0] next_line;
  assign next_line = line_addr + ADDR_WIDTH'(LINE_BYTES);

  // Presence check for the sequential successor line.
  always_comb begin
    next_hit_c = 1'b0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if (entries[i].valid && (entries[i].tag[ADDR_WIDTH-1:0] == next_line)) begin
        next_hit_c = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pipeline_fetch_lb.sv
// Instruction fetch stage backed by a small round-robin line buffer.
// One memory line request may be outstanding at a time.
// Optional next-line prefetch: define FETCH_PREFETCH_EN.
module pipeline_fetch_lb
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           LINE_BITS   = 512,
  parameter int unsigned           NUM_LINES   = 2,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [LINE_BITS-1:0]   mem_resp_data
);

  localparam int unsigned LINE_BYTES  = LINE_BITS / 8;
  localparam int unsigned INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int unsigned PTR_W       = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(NUM_LINES - 1);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_next;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [PTR_W-1:0]      ptr;
  logic                  drop, drop_next;
  logic                  fill_c;
  logic                  hit_c;
  logic [INSTR_WIDTH-1:0] instr_c;
  line_entry_t           entries [NUM_LINES];

  assign line_addr = pc & ~OFF_MASK;

`ifdef FETCH_PREFETCH_EN
  logic                  next_hit_c;
  logic [ADDR_WIDTH-1:0] next_line;
  assign next_line = line_addr + ADDR_WIDTH'(LINE_BYTES);
`endif

  fetch_line_lookup #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .LINE_BITS   (LINE_BITS),
    .NUM_LINES   (NUM_LINES),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_lookup (
    .entries    (entries),
    .pc         (pc),
`ifdef FETCH_PREFETCH_EN
    .next_hit_c (next_hit_c),
`endif
    .hit_c      (hit_c),
    .instr_c    (instr_c)
  );

  // A hit is presented unless the PC is being replaced or the buffer invalidated.
  assign out_valid     = hit_c && !redirect_valid && !flush;
  assign out_pc        = pc;
  assign out_instr     = instr_c;
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = req_addr;

  // Next-state logic for the single-outstanding-request miss handler.
  always_comb begin
    state_next    = state;
    req_addr_next = req_addr;
    drop_next     = drop;
    fill_c        = 1'b0;
    case (state)
      IDLE: begin
        drop_next = 1'b0;
        // A redirecting PC is about to be replaced, so its miss is not worth fetching.
        if (!hit_c && !redirect_valid) begin
          state_next    = REQ;
          req_addr_next = line_addr;
        end
`ifdef FETCH_PREFETCH_EN
        else if (hit_c && !next_hit_c && !redirect_valid && !flush) begin
          state_next    = REQ;
          req_addr_next = next_line;
        end
`endif
      end
      REQ: begin
        if (mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          // Data fetched before a flush may be stale, so it is discarded.
          fill_c     = !drop && !flush;
          drop_next  = 1'b0;
          state_next = IDLE;
        end else if (flush) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Miss handler state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_addr <= '0;
      drop     <= 1'b0;
    end else begin
      state    <= state_next;
      req_addr <= req_addr_next;
      drop     <= drop_next;
    end
  end

  // Fetch PC: redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~ALIGN_MASK;
    end else if (out_valid && out_ready) begin
      pc <= pc + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  // Line buffer storage with round-robin replacement.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        entries[i] <= '0;
      end
      ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        entries[i].valid <= 1'b0;
      end
    end else if (fill_c) begin
      entries[ptr].valid <= 1'b1;
      entries[ptr].tag   <= FETCH_TAG_MAX_W'(req_addr);
      entries[ptr].data  <= FETCH_DATA_MAX_W'(mem_resp_data);
      ptr                <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule
